// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: per-LED colour memory plus a free-running LATCH/SEND
// serialiser that refreshes the whole chain on one data pin.
module ws2812_chain_driver #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned T_BIT    = 13,
  parameter int unsigned T0H      = 4,
  parameter int unsigned T1H      = 8,
  parameter int unsigned T_RESET  = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [7:0]  led_num,
  input  logic [23:0] rgb_data,
  output logic        data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned GAP_W = $clog2(T_RESET);
  localparam int unsigned TMR_W = $clog2(T_BIT);
  localparam int unsigned LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned BIT_W = 5;

  typedef enum logic {
    ST_LATCH = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [LED_W-1:0]  r_led, w_led_nxt;
  logic [23:0]       r_shift, w_shift_nxt;
  logic              w_data_nxt, w_busy_nxt, w_done_nxt;

  logic [23:0]       r_mem [NUM_LEDS];
  logic [LED_W-1:0]  w_wr_idx;
  logic              w_wr_ok;

  // Wire order is G, R, B, each MSB first.
  function automatic logic [23:0] grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  assign w_wr_idx = led_num[LED_W-1:0];
  assign w_wr_ok  = write && ({1'b0, led_num} < 9'(NUM_LEDS));

  // Colour store; reads in the same cycle see the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        r_mem[LED_W'(i)] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[w_wr_idx] <= rgb_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_LATCH;
      r_gap      <= '0;
      r_timer    <= '0;
      r_bit      <= '0;
      r_led      <= '0;
      r_shift    <= '0;
      data       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_timer    <= w_timer_nxt;
      r_bit      <= w_bit_nxt;
      r_led      <= w_led_nxt;
      r_shift    <= w_shift_nxt;
      data       <= w_data_nxt;
      busy       <= w_busy_nxt;
      frame_done <= w_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_timer_nxt = r_timer;
    w_bit_nxt   = r_bit;
    w_led_nxt   = r_led;
    w_shift_nxt = r_shift;
    w_data_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_LATCH: begin
        if (r_gap == GAP_W'(T_RESET - 1)) begin
          w_state_nxt = ST_SEND;
          w_shift_nxt = grb(r_mem[0]);
          w_led_nxt   = '0;
          w_bit_nxt   = '0;
          w_timer_nxt = '0;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end

      ST_SEND: begin
        w_busy_nxt = 1'b1;
        w_data_nxt = r_shift[23] ? (r_timer < TMR_W'(T1H)) : (r_timer < TMR_W'(T0H));
        if (r_timer == TMR_W'(T_BIT - 1)) begin
          w_timer_nxt = '0;
          if (r_bit < BIT_W'(23)) begin
            w_shift_nxt = {r_shift[22:0], 1'b0};
            w_bit_nxt   = r_bit + BIT_W'(1);
          end else if (r_led < LED_W'(NUM_LEDS - 1)) begin
            // Next LED is fetched on the last cycle of this bit, so no idle gap.
            w_led_nxt   = r_led + LED_W'(1);
            w_shift_nxt = grb(r_mem[r_led + LED_W'(1)]);
            w_bit_nxt   = '0;
          end else begin
            w_done_nxt  = 1'b1;
            w_gap_nxt   = '0;
            w_state_nxt = ST_LATCH;
          end
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_LATCH;
        w_gap_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Scoreboard bench: driver queues expected wire words per frame, a monitor
// decodes the serial line and compares each completed frame plus its timing.
module tb_ws2812_chain_driver;

  localparam int unsigned NLED   = 8;
  localparam int unsigned BUSY_N = 2496;
  localparam int unsigned GAP_N  = 600;
  localparam int unsigned PERIOD = 3096;
  localparam int unsigned LED_CY = 312;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [7:0]  led_num = 8'd0;
  logic [23:0] rgb_data = 24'd0;
  logic        data, busy, frame_done;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] exp_q [$];

  ws2812_chain_driver dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .led_num    (led_num),
    .rgb_data   (rgb_data),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                            input logic [23:0] w3, input logic [23:0] w4, input logic [23:0] w5,
                            input logic [23:0] w6, input logic [23:0] w7);
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
    exp_q.push_back(w4); exp_q.push_back(w5); exp_q.push_back(w6); exp_q.push_back(w7);
  endtask

  // ---------------- monitor ----------------
  logic        prev_rst = 1'b1;
  logic        prev_busy = 1'b0;
  logic        prev_fd = 1'b0;
  logic        gap_valid = 1'b0;
  logic        shape_ok = 1'b1;
  logic        fd_valid = 1'b0;
  logic        bitv;
  logic [12:0] pat = '0;
  int          gap_cnt = 0;
  int          busy_cnt = 0;
  int          pos = 0;
  int          nbit = 0;
  int          frame_idx = 0;
  int unsigned last_fd = 0;
  logic [23:0] words [NLED];
  logic [23:0] e;

  always @(negedge clk) begin
    if (prev_rst) begin
      gap_cnt   = 0;
      gap_valid = 1'b1;
      busy_cnt  = 0;
      pos       = 0;
      nbit      = 0;
      shape_ok  = 1'b1;
      fd_valid  = 1'b0;
      prev_busy = 1'b0;
      prev_fd   = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          if (gap_valid) check("latch gap length", 32'(gap_cnt), 32'(GAP_N));
          gap_valid = 1'b0;
          busy_cnt  = 0;
          pos       = 0;
          nbit      = 0;
          shape_ok  = 1'b1;
        end
        busy_cnt++;
        pat = {pat[11:0], data};
        pos++;
        if (pos == 13) begin
          pos = 0;
          case (pat)
            13'h1E00: bitv = 1'b0;
            13'h1FE0: bitv = 1'b1;
            default: begin bitv = 1'b0; shape_ok = 1'b0; end
          endcase
          if (nbit < 192) words[nbit / 24] = {words[nbit / 24][22:0], bitv};
          nbit++;
        end
      end else begin
        if (prev_busy) begin
          check($sformatf("frame %0d busy length", frame_idx), 32'(busy_cnt), 32'(BUSY_N));
          check($sformatf("frame %0d bit shapes", frame_idx), 32'(shape_ok), 32'd1);
          check($sformatf("frame %0d done on last bit", frame_idx), 32'(prev_fd), 32'd1);
          if (exp_q.size() < NLED) begin
            n_vec++;
            n_err++;
            $display("FAIL frame %0d: no expectation queued", frame_idx);
          end else begin
            for (int i = 0; i < NLED; i++) begin
              e = exp_q.pop_front();
              check($sformatf("frame %0d led %0d word", frame_idx, i), 32'(words[i]), 32'(e));
            end
          end
          frame_idx++;
          gap_cnt   = 0;
          gap_valid = 1'b1;
        end
        gap_cnt++;
      end
      if (frame_done) begin
        if (fd_valid) check("frame_done spacing", cyc - last_fd, PERIOD);
        last_fd  = cyc;
        fd_valid = 1'b1;
      end
      prev_busy = busy;
      prev_fd   = frame_done;
    end
    prev_rst = reset;
  end

  // ---------------- driver ----------------
  task automatic do_write(input logic [7:0] idx, input logic [23:0] rgb);
    @(posedge clk); #1;
    write = 1'b1; led_num = idx; rgb_data = rgb;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: frame_done timeout, got none, required pulse", tag);
    end
  endtask

  task automatic wait_busy_rise(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: busy timeout, got 0, required 1", tag);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset data", 32'(data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);

    // F1: idle memory, all zero bits
    push_frame(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    wait_fd("F1");

    // F2: colour order, LED7 data, out-of-range write ignored
    do_write(8'd0, 24'hFF0000);
    do_write(8'd7, 24'h123456);
    do_write(8'd8, 24'hFFFFFF);
    push_frame(24'h00FF00, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h341256);
    wait_fd("F2");

    // F3: writes during LED3 leave LED3/LED1 alone but reach LED5
    do_write(8'd3, 24'h0A0B0C);
    push_frame(24'h00FF00, 24'h0, 24'h0, 24'h0B0A0C, 24'h0, 24'h0000FF, 24'h0, 24'h341256);
    wait_busy_rise("F3 start");
    repeat (3 * LED_CY + 100) @(posedge clk);
    do_write(8'd3, 24'h00FF00);
    do_write(8'd5, 24'h0000FF);
    do_write(8'd1, 24'h00FFFF);
    wait_fd("F3");

    // F4: deferred writes now visible
    push_frame(24'h00FF00, 24'hFF00FF, 24'h0, 24'hFF0000, 24'h0, 24'h0000FF, 24'h0, 24'h341256);
    wait_fd("F4");

    // F5: all white, interrupted by reset at bit 50
    for (int i = 0; i < NLED; i++) do_write(8'(i), 24'hFFFFFF);
    wait_busy_rise("F5 start");
    repeat (50 * 13) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("busy before mid-frame reset", 32'(busy), 32'd1);
    @(negedge clk);
    check("data after mid-frame reset", 32'(data), 32'd0);
    check("busy after mid-frame reset", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // F6: memory cleared by reset
    push_frame(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    wait_fd("F6");

    // F7: last LED after reset
    do_write(8'd7, 24'hFFFFFF);
    push_frame(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
    wait_fd("F7");

    repeat (3) @(negedge clk);
    check("expectations consumed", 32'(exp_q.size()), 32'd0);
    check("frames observed", 32'(frame_idx), 32'd6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ws2812_chain_driver.md
Name: ws2812_chain_driver

Overview:
- Project-1 user block, directly downstream of the multi-project harness.
- Consumes the harness's one-cycle write strobe together with wishbone data fields: led_num from wbs_dat_i[31:24], rgb_data from wbs_dat_i[23:0].
- Stores one colour word per LED and continuously refreshes a WS2812 chain on a single serial output pin, which the harness routes to io_out[8].

Parameters:
- NUM_LEDS, 8, number of LEDs in chain; legal range 1..256.
- T_BIT, 13, clock cycles per data bit (1.3 us at 10 MHz).
- T0H, 4, high cycles for a 0 bit; must be < T1H.
- T1H, 8, high cycles for a 1 bit; must be < T_BIT.
- T_RESET, 600, low cycles of the latch gap (60 us at 10 MHz); must be ≥ 2.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- write, input, 1, one-cycle store strobe.
- led_num, input, 8, LED index to store.
- rgb_data, input, 24, colour word: [23:16]=R, [15:8]=G, [7:0]=B.
- data, output, 1, WS2812 serial line.
- busy, output, 1, high while bits are being sent; low during the latch gap.
- frame_done, output, 1, one-cycle pulse when the last bit of the last LED completes.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values:
  - data=0, busy=0, frame_done=0.
  - All NUM_LEDS colour words = 0.
  - State = LATCH, gap counter=0, bit timer=0, bit index=0, LED index=0.
- Store:
  - On write=1 with led_num < NUM_LEDS: mem[led_num] <= rgb_data.
  - led_num ≥ NUM_LEDS is ignored silently; no aliasing or wrap.
  - Writes are accepted in every state. The new value is visible to loads from the following cycle.
  - A load and a write to the same index in the same cycle loads the old value.
- State machine, two states, free-running after reset:
  - LATCH:
    - data=0, busy=0.
    - Gap counter counts 0..T_RESET-1.
    - On count T_RESET-1: shift <= mem[0], LED index=0, bit index=0, bit timer=0, go to SEND.
  - SEND:
    - busy=1.
    - Bit timer counts 0..T_BIT-1.
    - data = (timer < (shift[23] ? T1H : T0H)).
    - On timer T_BIT-1:
      - If bit index < 23: shift <= shift<<1, bit index++.
      - Else if LED index < NUM_LEDS-1: LED index++, shift <= mem[LED index+1] re-ordered, bit index=0.
      - Else: frame_done=1 for this one cycle (registered, visible the next cycle), gap counter=0, go to LATCH.
- Bit ordering: shift register loaded as {G,R,B}; transmitted MSB first: G7..G0, R7..R0, B7..B0.
- Continuity:
  - No idle cycles between bits or between LEDs.
  - LED-to-LED loads occur on the last cycle of the previous bit.
- Frame period, first SEND cycle to next first SEND cycle: NUM_LEDS*24*T_BIT + T_RESET cycles. Default is 2496+600 = 3096.
- data and busy are registered outputs; a frame's first high data cycle follows the LATCH exit by exactly one cycle.
- Tearing rule: the LED currently being shifted is never affected by writes. Writes to later LEDs in the same frame take effect in this frame; writes to earlier LEDs take effect next frame.
- Reset mid-frame:
  - data low and busy low on the cycle after reset is sampled.
  - Memory cleared.
  - A full T_RESET gap precedes the next frame.
- Counter widths:
  - Gap counter: clog2(T_RESET).
  - Bit timer: clog2(T_BIT).
  - Bit index: 5 bits.
  - LED index: clog2(NUM_LEDS), minimum 1 bit.
  - No overflow is possible within the legal parameter ranges.

Test Plan:
- Reset/idle:
  - Stimulus: assert reset 3 cycles, release, no writes.
  - Required: data=0 and busy=0 for exactly 600 cycles. Then 192 bits each high 4 of 13 cycles (all zeros). frame_done pulses once at cycle 600+2496.
- Colour ordering:
  - Stimulus: write led_num=0, rgb_data=0xFF0000.
  - Required: next frame's first 8 bits are 0s (4 high cycles). Bits 9-16 are 1s (8 high cycles). Bits 17-24 are 0s. LEDs 1-7 are all 0s.
- Out-of-range write:
  - Stimulus: write led_num=8, rgb_data=0xFFFFFF, then let a full frame pass.
  - Required: all 192 bits are 0s. The write to LED 7 is not corrupted.
- Mid-frame write:
  - Stimulus: during LED 3 transmission, write LED 3=0x00FF00 and LED 5=0x0000FF.
  - Required: LED 3 bits are unchanged this frame and show G=0xFF next frame. LED 5 shows B=0xFF in the current frame.
- Frame timing:
  - Stimulus: measure successive frame_done pulses.
  - Required: spacing is exactly 3096 cycles. busy is high for exactly 2496 cycles per frame. There are no gaps between bit periods.
- Reset mid-operation:
  - Stimulus: assert reset at bit 50 of a frame with LEDs loaded with 0xFFFFFF.
  - Required: data low the next cycle. The following frame transmits all 0s after a 600-cycle gap.
